// File: rtl/proc_param_pkg.sv
// ============================================================================
// Module   : proc_param_pkg
// Purpose  : Opcodes, FSM state type and IR field positions for proc_param.
//            Optional multiply opcode enabled by PROC_PARAM_MUL_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

package proc_param_pkg;

    localparam int IR_W  = 10;
    localparam int OP_LSB = 0;
    localparam int X_LSB  = 4;
    localparam int Y_LSB  = 7;

    localparam logic [3:0] OP_MV   = 4'h0;
    localparam logic [3:0] OP_MVI  = 4'h1;
    localparam logic [3:0] OP_MVNZ = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_SLL  = 4'hA;
    localparam logic [3:0] OP_SRL  = 4'hB;
    localparam logic [3:0] OP_JNZ  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EX1   = 3'd1,
        S_EX2   = 3'd2,
        S_EX3   = 3'd3,
        S_MEMW  = 3'd4
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
`ifdef PROC_PARAM_MUL_EN
        return ((op >= OP_ADD) && (op <= OP_SRL)) || (op == OP_MUL);
`else
        return (op >= OP_ADD) && (op <= OP_SRL);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/proc_param_alu.sv
// ============================================================================
// Module   : proc_param_alu
// Purpose  : Combinational ALU for proc_param; multiplier present only when
//            PROC_PARAM_MUL_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module proc_param_alu
    import proc_param_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    localparam logic [DATA_W-1:0] C_DATA_W = DATA_W'(DATA_W);

    logic w_shift_over;
    assign w_shift_over = (b_i >= C_DATA_W);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD: result_o = a_i + b_i;
            OP_SUB: result_o = a_i - b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLL: result_o = w_shift_over ? '0 : (a_i << b_i);
            OP_SRL: result_o = w_shift_over ? '0 : (a_i >> b_i);
`ifdef PROC_PARAM_MUL_EN
            OP_MUL: result_o = a_i * b_i;
`endif
            default: result_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/proc_param.sv
// ============================================================================
// Module   : proc_param
// Purpose  : Multi-cycle 8-register processor with req/ack data memory.
//            Build option PROC_PARAM_MUL_EN adds opcode D (multiply).
// Revision : 1.0
// ============================================================================
`default_nettype none

module proc_param
    import proc_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [PC_W-1:0]   pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires
);

    state_t              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [IR_W-1:0]     ir_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   g_q;
    logic [DATA_W-1:0]   r_q [8];
    logic                mem_req_q;
    logic                mem_we_q;
    logic [DATA_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic [3:0]          op;
    logic [2:0]          x;
    logic [2:0]          y;
    logic [DATA_W-1:0]   rx;
    logic [DATA_W-1:0]   ry;
    logic [DATA_W-1:0]   alu_res;
    logic [PC_W-1:0]     pc_inc_d;

    assign op       = ir_q[OP_LSB +: 4];
    assign x        = ir_q[X_LSB +: 3];
    assign y        = ir_q[Y_LSB +: 3];
    assign rx       = r_q[x];
    assign ry       = r_q[y];
    assign pc_inc_d = pc_q + PC_W'(1);

    assign pc        = pc_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    proc_param_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (op),
        .a_i      (a_q),
        .b_i      (ry),
        .result_o (alu_res)
    );

    // Done must fall in the ack cycle itself, so it is decoded from state.
    always_comb begin
        Done = 1'b0;
        case (state_q)
            S_EX1:   Done = !((op == OP_LD) || (op == OP_ST) || is_alu_op(op));
            S_EX3:   Done = 1'b1;
            S_MEMW:  Done = mem_ack;
            default: Done = 1'b0;
        endcase
    end

    always_comb begin
        BusWires = '0;
        case (state_q)
            S_FETCH: BusWires = DIN;
            S_EX1:   BusWires = (op == OP_MVI) ? DIN : ry;
            S_EX2:   BusWires = ry;
            S_EX3:   BusWires = g_q;
            S_MEMW:  BusWires = mem_we_q ? mem_wdata_q : mem_rdata;
            default: BusWires = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            g_q         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (Run) begin
                        ir_q    <= DIN[IR_W-1:0];
                        pc_q    <= pc_inc_d;
                        state_q <= S_EX1;
                    end
                end
                S_EX1: begin
                    state_q <= S_FETCH;
                    case (op)
                        OP_MV:   r_q[x] <= ry;
                        OP_MVI: begin
                            r_q[x] <= DIN;
                            pc_q   <= pc_inc_d;
                        end
                        OP_MVNZ: if (g_q != '0) r_q[x] <= ry;
                        OP_JNZ:  if (g_q != '0) pc_q <= ry[PC_W-1:0];
                        OP_LD, OP_ST: begin
                            mem_addr_q <= ry;
                            if (op == OP_ST) mem_wdata_q <= rx;
                            mem_we_q   <= (op == OP_ST);
                            mem_req_q  <= 1'b1;
                            state_q    <= S_MEMW;
                        end
                        default: begin
                            if (is_alu_op(op)) begin
                                a_q     <= rx;
                                state_q <= S_EX2;
                            end
                        end
                    endcase
                end
                S_EX2: begin
                    g_q     <= alu_res;
                    state_q <= S_EX3;
                end
                S_EX3: begin
                    r_q[x]  <= g_q;
                    state_q <= S_FETCH;
                end
                S_MEMW: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) r_q[x] <= mem_rdata;
                        state_q   <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_proc_param.sv
// ============================================================================
// Module   : tb_proc_param
// Purpose  : Directed bench for proc_param (ROM model + variable-latency
//            memory responder). Honours PROC_PARAM_MUL_EN for opcode D.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_proc_param;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Run = 1'b0;
    logic [15:0] DIN;
    logic [7:0]  pc;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        Done;
    logic [15:0] BusWires;

    logic [15:0] rom [256];
    assign DIN = rom[pc];

    always #5 Clock = ~Clock;

    proc_param #(.DATA_W(16), .PC_W(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .pc(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .Done(Done), .BusWires(BusWires)
    );

    int vec_cnt = 0;
    int miss = 0;

    // cycle counter and Done log, sampled on the pre-edge values
    int   cyc = 0;
    int   n_done = 0;
    int   done_cyc [512];
    logic done_ack [512];
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (Done) begin
            done_cyc[n_done % 512] <= cyc;
            done_ack[n_done % 512] <= mem_ack;
            n_done <= n_done + 1;
        end
    end

    // memory responder: ack after ack_delay extra cycles, checks stability
    logic        resp_en = 1'b1;
    logic        force_ack = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          unstable = 0;
    int          req_len = 0;
    int          n_st = 0;
    logic [15:0] cap_addr = 16'h0, cap_data = 16'h0;
    logic [15:0] st_addr = 16'h0, st_data = 16'h0;
    always @(negedge Clock) begin
        if (mem_req) begin
            if (wait_cnt == 0) begin
                cap_addr <= mem_addr;
                cap_data <= mem_wdata;
            end else if (mem_addr != cap_addr || mem_wdata != cap_data) begin
                unstable <= unstable + 1;
            end
            wait_cnt <= wait_cnt + 1;
            if (resp_en && wait_cnt == ack_delay) begin
                mem_ack <= 1'b1;
                req_len <= wait_cnt + 1;
                if (mem_we) begin
                    st_addr <= mem_addr;
                    st_data <= mem_wdata;
                    n_st    <= n_st + 1;
                end
            end else begin
                mem_ack <= force_ack;
            end
        end else begin
            wait_cnt <= 0;
            mem_ack  <= force_ack;
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vt [15];
    int   t0, d0;

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] x,
                                        input logic [2:0] y);
        return {6'b0, y, x, op};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Run = 1'b0;
        Resetn = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    endtask

    // Runs until n_instr Done pulses are seen, then drops Run so the FSM parks.
    task automatic run_prog(input int n_instr, input string nm);
        int i;
        @(negedge Clock);
        t0  = cyc;
        d0  = n_done;
        Run = 1'b1;
        for (i = 0; i < 200 && (n_done - d0) < n_instr; i++) @(negedge Clock);
        Run = 1'b0;
        if ((n_done - d0) < n_instr) begin
            miss++;
            vec_cnt++;
            $display("FAIL %s timeout: done %0d expected %0d", nm, n_done - d0, n_instr);
        end
        @(negedge Clock);
    endtask

    initial begin
        vt[0]  = '{4'h6, 16'hFFFF, 16'h0001, 16'h0000, 4};
        vt[1]  = '{4'h7, 16'h0000, 16'h0001, 16'hFFFF, 4};
        vt[2]  = '{4'h8, 16'h0F0F, 16'h00F0, 16'h0FFF, 4};
        vt[3]  = '{4'h9, 16'hFFFF, 16'h0001, 16'h0001, 4};
        vt[4]  = '{4'h9, 16'h0001, 16'hFFFF, 16'h0000, 4};
        vt[5]  = '{4'h9, 16'h7FFF, 16'h8000, 16'h0000, 4};
        vt[6]  = '{4'hA, 16'h0001, 16'h0004, 16'h0010, 4};
        vt[7]  = '{4'hA, 16'h1234, 16'h0010, 16'h0000, 4};
        vt[8]  = '{4'hA, 16'h8001, 16'h000F, 16'h8000, 4};
        vt[9]  = '{4'hB, 16'h8000, 16'h000F, 16'h0001, 4};
        vt[10] = '{4'hB, 16'hFFFF, 16'h0010, 16'h0000, 4};
        vt[11] = '{4'hB, 16'hF0F0, 16'h0004, 16'h0F0F, 4};
        vt[12] = '{4'h6, 16'h0003, 16'h0004, 16'h0007, 4};
`ifdef PROC_PARAM_MUL_EN
        vt[13] = '{4'hD, 16'h0007, 16'h0006, 16'h002A, 4};
`else
        vt[13] = '{4'hD, 16'h0007, 16'h0006, 16'h0007, 2};
`endif
        vt[14] = '{4'hE, 16'h0007, 16'h0006, 16'h0007, 2};

        clear_rom();
        do_reset();
        #1;
        chk("reset pc", 32'(pc), 32'h0);
        chk("reset mem_req", 32'(mem_req), 32'h0);
        chk("reset mem_we", 32'(mem_we), 32'h0);
        chk("reset Done", 32'(Done), 32'h0);

        // mvi R2,#0x1234 ; mv R5,R2
        clear_rom();
        rom[0] = enc(4'h1, 3'd2, 3'd0);
        rom[1] = 16'h1234;
        rom[2] = enc(4'h0, 3'd5, 3'd2);
        do_reset();
        run_prog(2, "mvi_mv");
        chk("mv R5", 32'(dut.r_q[5]), 32'h1234);
        chk("mvi done cycle", 32'(done_cyc[d0 % 512] - t0 + 1), 32'd2);
        chk("mv done cycle", 32'(done_cyc[(d0 + 1) % 512] - t0 + 1), 32'd4);
        chk("mvi_mv pc", 32'(pc), 32'h3);

        // ALU / NOP table: mvi R1,a ; mvi R2,b ; op R1,R2
        for (int k = 0; k < 15; k++) begin
            clear_rom();
            rom[0] = enc(4'h1, 3'd1, 3'd0);
            rom[1] = vt[k].a;
            rom[2] = enc(4'h1, 3'd2, 3'd0);
            rom[3] = vt[k].b;
            rom[4] = enc(vt[k].op, 3'd1, 3'd2);
            do_reset();
            run_prog(3, $sformatf("vec%0d", k));
            chk($sformatf("vec%0d R1", k), 32'(dut.r_q[1]), 32'(vt[k].exp));
            chk($sformatf("vec%0d latency", k),
                32'(done_cyc[(d0 + 2) % 512] - done_cyc[(d0 + 1) % 512]), 32'(vt[k].lat));
        end

        // X==Y: add R1,R1 doubles R1
        clear_rom();
        rom[0] = enc(4'h1, 3'd1, 3'd0);
        rom[1] = 16'h0021;
        rom[2] = enc(4'h6, 3'd1, 3'd1);
        do_reset();
        run_prog(2, "add_self");
        chk("add R1,R1", 32'(dut.r_q[1]), 32'h0042);

        // st R1,R2 with three extra wait cycles
        begin
            int st0, un0;
            clear_rom();
            rom[0] = enc(4'h1, 3'd1, 3'd0);
            rom[1] = 16'hCAFE;
            rom[2] = enc(4'h1, 3'd2, 3'd0);
            rom[3] = 16'h0040;
            rom[4] = enc(4'h5, 3'd1, 3'd2);
            do_reset();
            ack_delay = 3;
            st0 = n_st;
            un0 = unstable;
            run_prog(3, "store");
            chk("st count", 32'(n_st - st0), 32'd1);
            chk("st addr", 32'(st_addr), 32'h0040);
            chk("st wdata", 32'(st_data), 32'hCAFE);
            chk("st req cycles", 32'(req_len), 32'd4);
            chk("st stable", 32'(unstable - un0), 32'd0);
            chk("st done on ack", 32'(done_ack[(d0 + 2) % 512]), 32'h1);
            chk("st latency", 32'(done_cyc[(d0 + 2) % 512] - done_cyc[(d0 + 1) % 512]), 32'd6);
            ack_delay = 0;
        end

        // ld R6,R0 with zero wait
        clear_rom();
        rom[0] = enc(4'h4, 3'd6, 3'd0);
        do_reset();
        mem_rdata = 16'hBEEF;
        run_prog(1, "load");
        chk("ld R6", 32'(dut.r_q[6]), 32'hBEEF);
        chk("ld latency", 32'(done_cyc[d0 % 512] - t0 + 1), 32'd3);

        // jnz with G==0 falls through
        clear_rom();
        rom[0] = enc(4'hC, 3'd0, 3'd7);
        rom[1] = enc(4'h1, 3'd3, 3'd0);
        rom[2] = 16'h0055;
        do_reset();
        run_prog(2, "jnz_nt");
        chk("jnz not taken R3", 32'(dut.r_q[3]), 32'h0055);
        chk("jnz not taken pc", 32'(pc), 32'h3);

        // jnz with G==5 to 0x10
        clear_rom();
        rom[0]  = enc(4'h1, 3'd1, 3'd0);
        rom[1]  = 16'h0002;
        rom[2]  = enc(4'h1, 3'd2, 3'd0);
        rom[3]  = 16'h0003;
        rom[4]  = enc(4'h6, 3'd1, 3'd2);
        rom[5]  = enc(4'h1, 3'd7, 3'd0);
        rom[6]  = 16'h0010;
        rom[7]  = enc(4'hC, 3'd0, 3'd7);
        rom[8]  = enc(4'h1, 3'd4, 3'd0);
        rom[9]  = 16'h0099;
        rom[16] = enc(4'h1, 3'd4, 3'd0);
        rom[17] = 16'h0077;
        do_reset();
        run_prog(6, "jnz_t");
        chk("jnz taken R4", 32'(dut.r_q[4]), 32'h0077);
        chk("jnz taken pc", 32'(pc), 32'h12);

        // reset asserted mid-MEMW, then a late ack
        begin
            int i, dn0;
            clear_rom();
            rom[0] = enc(4'h1, 3'd1, 3'd0);
            rom[1] = 16'hAAAA;
            rom[2] = enc(4'h5, 3'd1, 3'd0);
            do_reset();
            resp_en = 1'b0;
            @(negedge Clock);
            Run = 1'b1;
            for (i = 0; i < 50 && !mem_req; i++) @(negedge Clock);
            Run = 1'b0;
            chk("memw reached", 32'(mem_req), 32'h1);
            @(negedge Clock);
            @(posedge Clock);
            #2;
            Resetn = 1'b0;
            #1;
            chk("async reset mem_req", 32'(mem_req), 32'h0);
            chk("async reset pc", 32'(pc), 32'h0);
            @(negedge Clock);
            Resetn = 1'b1;
            dn0 = n_done;
            @(posedge Clock);
            #2;
            force_ack = 1'b1;
            @(posedge Clock);
            #2;
            force_ack = 1'b0;
            @(negedge Clock);
            @(negedge Clock);
            chk("late ack mem_req", 32'(mem_req), 32'h0);
            chk("late ack pc", 32'(pc), 32'h0);
            chk("late ack no Done", 32'(n_done - dn0), 32'd0);
            chk("late ack R1", 32'(dut.r_q[1]), 32'h0);
            resp_en = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end

endmodule

`default_nettype wire
